pack_8to16: RTL and testbench
=============================

# pack_8to16

- Stream width upsizer that sits directly upstream of the 16-bit valid/ready sink.
- Accepts 8-bit words on a valid/ready source port, pairs consecutive words into one 16-bit word, and presents it on a valid/ready destination port.
- A 2-entry output FIFO decouples the two handshakes, so `src_rdy` never depends combinationally on `dst_rdy`.
- `cfg_en` gates both ports, matching the sink's enable semantics.

## Interface
- `IWIDTH`, 8, input word width; output width is fixed at 2*IWIDTH.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cfg_en`  in  1  enable, active-high; the protocol may be violated on disable.
- `src_val`  in  1  source valid.
- `src_rdy`  out  1  source ready.
- `src_data`  in  IWIDTH  source data, steady while valid.
- `dst_val`  out  1  destination valid.
- `dst_rdy`  in  1  destination ready.
- `dst_data`  out  2*IWIDTH  destination data, steady while valid and not accepted.

## Operation
- Transfers occur only on `clk` edges where val && rdy.
- Pairing state `half_vld` is 0 when no byte is held. It is 1 when the first byte of a pair is held in `half_reg`.
- Source accept with `half_vld`=0: `half_reg` <= `src_data`, `half_vld` <= 1.
- Source accept with `half_vld`=1: push {second, first} into the FIFO (first byte in bits [IWIDTH-1:0]), then `half_vld` <= 0.
- FIFO: depth 2, with a 2-bit count (0..2), 1-bit read and write pointers, and wrap at 2.
- `dst_data` = FIFO head entry; storage is cleared to 0 on reset.
- `src_rdy` = `cfg_en` && !(`half_vld` && count==2). It is a function of registered state only.
- `dst_val` = `cfg_en` && count!=0.
- Same-cycle pop and push: count is unchanged, and both pointers advance.
- Count==2 with `half_vld`=1 gives `src_rdy`=0 even when `dst_rdy`=1 in that cycle. The slot freed by a pop becomes visible on the next cycle.
- `cfg_en`=0: no transfer on either port. All state, including a held half word, is retained. Operation resumes unchanged when `cfg_en` returns to 1.
- Data is never dropped or duplicated. The word order at the output equals the byte-pair order at the input.

## Timing
- Reset (`rst`=1 at an edge) sets `half_vld`, count, pointers and FIFO storage to 0.
- After reset: `dst_val`=0, `dst_data`=0, and `src_rdy`=`cfg_en`.
- `rst` has priority over any handshake in the same cycle. A transfer in progress when `rst` is asserted is discarded, including a held half word and FIFO contents.
- Latency: second byte accepted at edge N, then `dst_val`=1 with that word from N (visible in cycle N+1).
- A FIFO entry popped at edge N exposes the next entry in cycle N+1.
- Throughput: one 16-bit word per 2 clocks with `src_val` and `dst_rdy` held at 1.
- `src_rdy` stays 1 continuously in steady state.
- With `dst_rdy`=0 the block absorbs 5 bytes (2 full entries plus 1 half), then deasserts `src_rdy`.

## Configuration
- Macro `PACK_8TO16_MSB_FIRST_EN`.
- Undefined: the first accepted byte is placed in `dst_data[IWIDTH-1:0]` (little-endian packing).
- Defined: the first accepted byte is placed in `dst_data[2*IWIDTH-1:IWIDTH]`, and the second byte in the low half.
- All timing and handshake behaviour is identical in both builds.

## Test plan
- Streaming: `cfg_en`=1, `dst_rdy`=1, bytes 0x11,0x22,0x33,0x44.
  - Required: outputs 0x2211 then 0x4433, one word per 2 cycles.
  - With the macro defined: 0x1122, 0x3344.
- Backpressure: `dst_rdy`=0, `src_val`=1, bytes 0x01..0x06.
  - Required: exactly 5 bytes accepted, then `src_rdy`=0.
  - Release `dst_rdy`: outputs 0x0201, 0x0403, 0x0605, with no loss.
- Full with same-cycle pop: count=2, `half_vld`=1, `dst_rdy`=1 for one cycle.
  - Required: `src_rdy`=0 that cycle and 1 the next; count 2 goes to 1.
- Enable gating: send 0xAA, drop `cfg_en` for 4 cycles while `src_val`=1 with 0xBB.
  - Required: `src_rdy`=0 and `dst_val`=0 throughout.
  - On re-enable, 0xBB is accepted and 0xBBAA is output.
- Mid-operation reset: one full FIFO entry plus a held byte, then pulse `rst`.
  - Required: next cycle `dst_val`=0, `dst_data`=0.
  - The next two bytes 0x5A,0xA5 produce 0xA55A.
- Random: random `src_val` and `dst_rdy` over 10k cycles.
  - Required: scoreboard matches every packed pair in order, and data stays stable while `dst_val` && !`dst_rdy`.

Source files
------------

// File: rtl/pack_8to16.sv
// Stream upsizer: pairs consecutive IWIDTH-bit words into 2*IWIDTH-bit words behind a 2-entry FIFO.
// Define PACK_8TO16_MSB_FIRST_EN to place the first byte of a pair in the upper half of the output.
module pack_8to16 #(
  parameter int IWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic                  src_val,
  output logic                  src_rdy,
  input  logic [IWIDTH-1:0]     src_data,
  output logic                  dst_val,
  input  logic                  dst_rdy,
  output logic [2*IWIDTH-1:0]   dst_data
);

  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_state_t;

  pair_state_t state_q, state_d;

  logic [IWIDTH-1:0]   half_reg;
  logic [2*IWIDTH-1:0] fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic                half_vld;
  logic                src_fire;
  logic                dst_fire;
  logic                push;
  logic [2*IWIDTH-1:0] pair_word;

  // src_rdy looks only at registered state, so a pop never frees a slot combinationally
  assign half_vld = (state_q == PAIR_HALF);
  assign src_rdy  = cfg_en && !(half_vld && (count == 2'd2));
  assign dst_val  = cfg_en && (count != 2'd0);
  assign dst_data = fifo_mem[rd_ptr];

  assign src_fire = src_val && src_rdy;
  assign dst_fire = dst_val && dst_rdy;
  assign push     = src_fire && half_vld;

`ifdef PACK_8TO16_MSB_FIRST_EN
  assign pair_word = {half_reg, src_data};
`else
  assign pair_word = {src_data, half_reg};
`endif

  always_comb begin
    state_d = state_q;
    if (src_fire) begin
      if (half_vld) state_d = PAIR_EMPTY;
      else          state_d = PAIR_HALF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PAIR_EMPTY;
      half_reg    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      state_q <= state_d;
      if (src_fire && !half_vld) half_reg <= src_data;
      if (push) begin
        fifo_mem[wr_ptr] <= pair_word;
        wr_ptr           <= ~wr_ptr;
      end
      if (dst_fire) rd_ptr <= ~rd_ptr;
      // simultaneous push and pop leave the occupancy unchanged
      case ({push, dst_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_8to16.sv
// Self-checking bench for pack_8to16: directed scenarios plus a randomized run against a byte-pair queue model.
module tb_pack_8to16;

  localparam int IW = 8;

  logic          clk;
  logic          rst;
  logic          cfg_en;
  logic          src_val;
  logic          src_rdy;
  logic [IW-1:0] src_data;
  logic          dst_val;
  logic          dst_rdy;
  logic [2*IW-1:0] dst_data;

  int vectors;
  int miscompares;

  logic [15:0] exp_q[$];
  logic [15:0] pop_log[$];
  logic        held;
  logic [7:0]  held_byte;
  logic        stall_prev;
  logic [15:0] stall_data;
  int          cyc;
  int          last_pop_cyc;
  int          pop_gap;

  pack_8to16 #(.IWIDTH(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .src_val  (src_val),
    .src_rdy  (src_rdy),
    .src_data (src_data),
    .dst_val  (dst_val),
    .dst_rdy  (dst_rdy),
    .dst_data (dst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
`ifdef PACK_8TO16_MSB_FIRST_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Drive inputs for one cycle; took reports whether the source handshake fires at the coming edge
  task automatic applyStimulus(input logic r, input logic en, input logic sv,
                               input logic [7:0] sd, input logic dr, output logic took);
    rst      = r;
    cfg_en   = en;
    src_val  = sv;
    src_data = sd;
    dst_rdy  = dr;
    @(negedge clk);
    took = src_val && src_rdy && !rst;
    @(posedge clk);
    #1;
  endtask

  // Reference model: bytes pair up in arrival order, words leave in order, capacity two words plus a byte
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      held       = 1'b0;
      stall_prev = 1'b0;
    end else begin
      checkOutput("dst_val", 16'(dst_val), 16'(cfg_en && exp_q.size() != 0));
      checkOutput("src_rdy", 16'(src_rdy), 16'(cfg_en && !(held && exp_q.size() >= 2)));
      if (stall_prev && cfg_en) checkOutput("stable", dst_data, stall_data);
      if (dst_val && exp_q.size() != 0) checkOutput("dst_data", dst_data, exp_q[0]);
      if (dst_val && dst_rdy) begin
        pop_log.push_back(dst_data);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        pop_gap      = cyc - last_pop_cyc;
        last_pop_cyc = cyc;
      end
      if (src_val && src_rdy) begin
        if (held) begin
          exp_q.push_back(pack(held_byte, src_data));
          held = 1'b0;
        end else begin
          held_byte = src_data;
          held      = 1'b1;
        end
      end
      stall_prev = dst_val && !dst_rdy;
      stall_data = dst_data;
    end
  end

  initial begin
    logic       took;
    logic       sv;
    logic [7:0] sd;
    logic       en;
    int         idx;
    logic [7:0] bp_bytes [6];

    vectors = 0; miscompares = 0; cyc = 0; last_pop_cyc = 0; pop_gap = 0;
    held = 1'b0; held_byte = '0; stall_prev = 1'b0; stall_data = '0;
    rst = 1'b1; cfg_en = 1'b0; src_val = 1'b0; src_data = '0; dst_rdy = 1'b0;

    // Reset state
    applyStimulus(1, 1, 0, 8'h00, 0, took);
    applyStimulus(1, 1, 0, 8'h00, 0, took);
    checkOutput("rst_dst_val", 16'(dst_val), 16'd0);
    checkOutput("rst_dst_data", dst_data, 16'h0000);
    checkOutput("rst_src_rdy", 16'(src_rdy), 16'd1);

    // Streaming
    pop_log.delete();
    applyStimulus(0, 1, 1, 8'h11, 1, took);
    applyStimulus(0, 1, 1, 8'h22, 1, took);
    applyStimulus(0, 1, 1, 8'h33, 1, took);
    applyStimulus(0, 1, 1, 8'h44, 1, took);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 1, took);
    checkOutput("stream_cnt", 16'(pop_log.size()), 16'd2);
    checkOutput("stream_gap", 16'(pop_gap), 16'd2);
`ifdef PACK_8TO16_MSB_FIRST_EN
    if (pop_log.size() >= 2) begin
      checkOutput("stream_w0", pop_log[0], 16'h1122);
      checkOutput("stream_w1", pop_log[1], 16'h3344);
    end
`else
    if (pop_log.size() >= 2) begin
      checkOutput("stream_w0", pop_log[0], 16'h2211);
      checkOutput("stream_w1", pop_log[1], 16'h4433);
    end
`endif

    // Backpressure, then full FIFO with a same-cycle pop
    pop_log.delete();
    for (int i = 0; i < 6; i++) bp_bytes[i] = 8'(i + 1);
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, bp_bytes[idx], 0, took);
      if (took && idx < 5) idx++;
    end
    checkOutput("bp_accepted", 16'(idx), 16'd5);
    checkOutput("bp_src_rdy", 16'(src_rdy), 16'd0);
    applyStimulus(0, 1, 1, bp_bytes[5], 1, took);
    checkOutput("full_pop_rdy", 16'(took), 16'd0);
    checkOutput("full_pop_next", 16'(src_rdy), 16'd1);
    applyStimulus(0, 1, 1, bp_bytes[5], 1, took);
    checkOutput("bp_last_take", 16'(took), 16'd1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h00, 1, took);
    checkOutput("bp_cnt", 16'(pop_log.size()), 16'd3);
    if (pop_log.size() >= 3) begin
      checkOutput("bp_w0", pop_log[0], pack(8'h01, 8'h02));
      checkOutput("bp_w1", pop_log[1], pack(8'h03, 8'h04));
      checkOutput("bp_w2", pop_log[2], pack(8'h05, 8'h06));
    end

    // Enable gating with a held half word
    pop_log.delete();
    applyStimulus(0, 1, 1, 8'hAA, 1, took);
    checkOutput("en_take_aa", 16'(took), 16'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 8'hBB, 1, took);
      checkOutput("en_off_take", 16'(took), 16'd0);
      checkOutput("en_off_rdy", 16'(src_rdy), 16'd0);
      checkOutput("en_off_val", 16'(dst_val), 16'd0);
    end
    applyStimulus(0, 1, 1, 8'hBB, 1, took);
    checkOutput("en_take_bb", 16'(took), 16'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 1, took);
    checkOutput("en_cnt", 16'(pop_log.size()), 16'd1);
    if (pop_log.size() >= 1) checkOutput("en_word", pop_log[0], pack(8'hAA, 8'hBB));

    // Mid-operation reset discards a full entry and a held byte
    pop_log.delete();
    applyStimulus(0, 1, 1, 8'h01, 0, took);
    applyStimulus(0, 1, 1, 8'h02, 0, took);
    applyStimulus(0, 1, 1, 8'h03, 0, took);
    checkOutput("mr_dst_val_pre", 16'(dst_val), 16'd1);
    applyStimulus(1, 1, 0, 8'h00, 0, took);
    checkOutput("mr_dst_val", 16'(dst_val), 16'd0);
    checkOutput("mr_dst_data", dst_data, 16'h0000);
    applyStimulus(0, 1, 1, 8'h5A, 1, took);
    applyStimulus(0, 1, 1, 8'hA5, 1, took);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 1, took);
    checkOutput("mr_cnt", 16'(pop_log.size()), 16'd1);
    if (pop_log.size() >= 1) checkOutput("mr_word", pop_log[0], pack(8'h5A, 8'hA5));

    // Random traffic; the source holds valid and data until accepted
    sv = 1'b0; sd = 8'h00; took = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(sv && !took)) begin
        sv = 1'($urandom_range(0, 1));
        sd = 8'($urandom);
      end
      en = ($urandom_range(0, 7) != 0);
      applyStimulus(0, en, sv, sd, 1'($urandom_range(0, 1)), took);
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h00, 1, took);
    checkOutput("drain_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
